// File: rtl/mem_access_stage_pkg.sv
// Shared types and widths for the memory-access pipeline stage.
package mem_access_stage_pkg;

    localparam int unsigned N  = 32;
    localparam int unsigned RW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [N-1:0]  result;
        logic [N-1:0]  ax;
        logic [N-1:0]  ay;
        logic [RW-1:0] rd;
        logic          reg_write;
    } mem_wb_interface_t;

    // A bundle needs the data port when it loads, stores, or both.
    function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
        return mem_read | mem_write;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Execute-side, data-memory and writeback-side signals of the memory-access stage.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_alu_result;
    logic [N-1:0]  in_wd;
    logic [N-1:0]  in_ax;
    logic [N-1:0]  in_ay;
    logic [RW-1:0] in_rd;
    logic          in_reg_write;
    logic          in_mem_read;
    logic          in_mem_write;

    logic          mem_req;
    logic          mem_we;
    logic [N-1:0]  mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          mem_ack;
    logic [N-1:0]  mem_rdata;

    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic [N-1:0]  out_ax;
    logic [N-1:0]  out_ay;
    logic [RW-1:0] out_rd;
    logic          out_reg_write;

    logic [N-1:0]  fwd_mem;
    logic          stall;

    modport slave (
        input  in_valid, in_alu_result, in_wd, in_ax, in_ay, in_rd,
               in_reg_write, in_mem_read, in_mem_write,
               mem_ack, mem_rdata, out_ready,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               out_valid, out_result, out_ax, out_ay, out_rd, out_reg_write,
               fwd_mem, stall
    );

    modport master (
        output in_valid, in_alu_result, in_wd, in_ax, in_ay, in_rd,
               in_reg_write, in_mem_read, in_mem_write,
               mem_ack, mem_rdata, out_ready,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               out_valid, out_result, out_ax, out_ay, out_rd, out_reg_write,
               fwd_mem, stall
    );

endinterface

// File: rtl/mem_access_stage_mem_req_fsm.sv
// Stage state machine: owns the data-memory request registers and detects
// the completion pulse of the outstanding access.
module mem_access_stage_mem_req_fsm
    import mem_access_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         start_we_i,
    input  logic [N-1:0] start_addr_i,
    input  logic [N-1:0] start_wdata_i,
    input  logic         mem_ack_i,
    input  logic         out_ready_i,
    output mem_state_t   state_o,
    output logic         ack_hit_c_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [N-1:0] mem_addr_o,
    output logic [N-1:0] mem_wdata_o
);

    mem_state_t   state_q, state_d;
    logic         req_q, req_d;
    logic         we_q, we_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic         ack_hit;

    // Acks outside an outstanding request are stray and ignored.
    assign ack_hit = (state_q == ACCESS) && req_q && mem_ack_i;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = start_we_i;
                    addr_d  = start_addr_i;
                    wdata_d = start_wdata_i;
                end
            end
            ACCESS: begin
                if (ack_hit) begin
                    req_d   = 1'b0;
                    state_d = out_ready_i ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign state_o     = state_q;
    assign ack_hit_c_o = ack_hit;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: captures an execute bundle, performs the
// optional load/store, and presents the registered result to writeback.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mem_access_stage_if.slave  bus
);

    mem_state_t        state;
    logic              ack_hit_c;
    logic              mem_we;
    logic              in_ready_c;
    logic              xfer_c;
    logic              mem_op_c;
    logic              start_c;
    mem_wb_interface_t bundle_c;

    mem_wb_interface_t cap_q, cap_d;
    mem_wb_interface_t out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [N-1:0]      fwd_q, fwd_d;

    assign in_ready_c = (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign xfer_c     = bus.in_valid && in_ready_c;
    assign mem_op_c   = is_mem_op(bus.in_mem_read, bus.in_mem_write);
    assign start_c    = xfer_c && mem_op_c;
    assign bundle_c   = '{result:    bus.in_alu_result,
                          ax:        bus.in_ax,
                          ay:        bus.in_ay,
                          rd:        bus.in_rd,
                          reg_write: bus.in_reg_write};

    // A combined read+write goes out as a store.
    mem_access_stage_mem_req_fsm u_fsm (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_c),
        .start_we_i    (bus.in_mem_write),
        .start_addr_i  (bus.in_alu_result),
        .start_wdata_i (bus.in_wd),
        .mem_ack_i     (bus.mem_ack),
        .out_ready_i   (bus.out_ready),
        .state_o       (state),
        .ack_hit_c_o   (ack_hit_c),
        .mem_req_o     (bus.mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (bus.mem_addr),
        .mem_wdata_o   (bus.mem_wdata)
    );

    always_comb begin
        cap_d       = cap_q;
        out_d       = out_q;
        fwd_d       = fwd_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        if (!out_valid_d) begin
            out_d.reg_write = 1'b0;
        end
        if (xfer_c) begin
            cap_d = bundle_c;
            fwd_d = bus.in_alu_result;
            if (!mem_op_c) begin
                out_d       = bundle_c;
                out_valid_d = 1'b1;
            end
        end
        // Stores retire the captured ALU result and never write a register.
        if (ack_hit_c) begin
            out_d       = cap_q;
            out_valid_d = 1'b1;
            if (mem_we) begin
                out_d.reg_write = 1'b0;
            end else begin
                out_d.result = bus.mem_rdata;
                fwd_d        = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            fwd_q       <= '0;
        end else begin
            cap_q       <= cap_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            fwd_q       <= fwd_d;
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.stall         = bus.in_valid && !in_ready_c;
    assign bus.mem_we        = mem_we;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = out_q.result;
    assign bus.out_ax        = out_q.ax;
    assign bus.out_ay        = out_q.ay;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_reg_write = out_q.reg_write;
    assign bus.fwd_mem       = fwd_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scenarios followed by a randomized traffic run scored against a
// transaction-level model of the memory-access stage.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int unsigned K = 80;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] ax;
        logic [31:0] ay;
        logic [3:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } txn_t;

    typedef struct {
        logic [31:0] result;
        logic [31:0] ax;
        logic [31:0] ay;
        logic [3:0]  rd;
        logic        rw;
    } exp_out_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_mem_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] ax, input logic [31:0] ay,
                         input logic [3:0] rd, input logic rw,
                         input logic mr, input logic mw);
        bus.in_valid      = 1'b1;
        bus.in_alu_result = alu;
        bus.in_wd         = wd;
        bus.in_ax         = ax;
        bus.in_ay         = ay;
        bus.in_rd         = rd;
        bus.in_reg_write  = rw;
        bus.in_mem_read   = mr;
        bus.in_mem_write  = mw;
    endtask

    task automatic ack(input logic a, input logic [31:0] rdata);
        bus.mem_ack   = a;
        bus.mem_rdata = rdata;
    endtask

    txn_t     txns[$];
    exp_out_t exp_q[$];
    exp_mem_t mreq_q[$];

    initial begin
        int  ti;
        int  acc;
        int  nout;
        int  cyc;
        int  wait_cnt;
        bit  req_seen;
        txn_t     t;
        exp_out_t e;
        exp_mem_t m;

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        ack(0, 0);
        repeat (2) next_cycle();
        rst = 1'b1;
        sample();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_fwd", bus.fwd_mem, 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_stall", 32'(bus.stall), 0);

        // ALU op: one-cycle latency, no memory request
        next_cycle();
        drive(32'h15, 32'h0, 32'hA, 32'hB, 4'd3, 1, 0, 0);
        sample();
        chk("alu_in_ready", 32'(bus.in_ready), 1);
        next_cycle();
        bus.in_valid = 1'b0;
        sample();
        chk("alu_out_valid", 32'(bus.out_valid), 1);
        chk("alu_out_result", bus.out_result, 32'h15);
        chk("alu_out_rd", 32'(bus.out_rd), 3);
        chk("alu_out_rw", 32'(bus.out_reg_write), 1);
        chk("alu_out_ax", bus.out_ax, 32'hA);
        chk("alu_out_ay", bus.out_ay, 32'hB);
        chk("alu_no_req", 32'(bus.mem_req), 0);
        chk("alu_fwd", bus.fwd_mem, 32'h15);
        next_cycle();
        sample();
        chk("alu_drained", 32'(bus.out_valid), 0);
        chk("alu_rw_qualified", 32'(bus.out_reg_write), 0);
        next_cycle();
        ack(1, 32'hBAD);
        sample();
        chk("stray_ack_no_req", 32'(bus.mem_req), 0);
        next_cycle();
        ack(0, 0);
        sample();
        chk("stray_ack_no_valid", 32'(bus.out_valid), 0);
        chk("stray_ack_fwd", bus.fwd_mem, 32'h15);

        // Load with ack in the third request cycle, upstream held valid
        next_cycle();
        drive(32'h40, 32'h0, 32'h1, 32'h2, 4'd5, 1, 1, 0);
        sample();
        chk("ld_in_ready", 32'(bus.in_ready), 1);
        next_cycle();
        drive(32'h77, 32'h0, 32'h3, 32'h4, 4'd6, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            ack(i == 2, (i == 2) ? 32'hDEADBEEF : 32'h0);
            sample();
            chk("ld_req", 32'(bus.mem_req), 1);
            chk("ld_addr", bus.mem_addr, 32'h40);
            chk("ld_we", 32'(bus.mem_we), 0);
            chk("ld_stall", 32'(bus.stall), 1);
            chk("ld_fwd_capture", bus.fwd_mem, (i == 0) ? 32'h40 : bus.fwd_mem);
        end
        next_cycle();
        ack(0, 0);
        sample();
        chk("ld_req_drop", 32'(bus.mem_req), 0);
        chk("ld_out_valid", 32'(bus.out_valid), 1);
        chk("ld_out_result", bus.out_result, 32'hDEADBEEF);
        chk("ld_fwd", bus.fwd_mem, 32'hDEADBEEF);
        chk("ld_out_rd", 32'(bus.out_rd), 5);
        chk("ld_out_rw", 32'(bus.out_reg_write), 1);
        chk("ld_stall_release", 32'(bus.stall), 0);
        next_cycle();
        bus.in_valid = 1'b0;
        sample();
        chk("b2b_out_result", bus.out_result, 32'h77);
        chk("b2b_out_valid", 32'(bus.out_valid), 1);
        next_cycle();
        sample();
        chk("b2b_drained", 32'(bus.out_valid), 0);

        // Store acked in its first request cycle
        next_cycle();
        drive(32'h08, 32'h1234, 32'h0, 32'h0, 4'd7, 1, 0, 1);
        sample();
        next_cycle();
        bus.in_valid = 1'b0;
        ack(1, 32'hFFFFFFFF);
        sample();
        chk("st_req", 32'(bus.mem_req), 1);
        chk("st_we", 32'(bus.mem_we), 1);
        chk("st_wdata", bus.mem_wdata, 32'h1234);
        chk("st_addr", bus.mem_addr, 32'h08);
        chk("st_busy", 32'(bus.in_ready), 0);
        next_cycle();
        ack(0, 0);
        sample();
        chk("st_out_valid", 32'(bus.out_valid), 1);
        chk("st_out_result", bus.out_result, 32'h08);
        chk("st_no_rw", 32'(bus.out_reg_write), 0);
        chk("st_in_ready", 32'(bus.in_ready), 1);
        chk("st_fwd", bus.fwd_mem, 32'h08);
        next_cycle();
        sample();

        // Completed load held by writeback back-pressure
        next_cycle();
        drive(32'h20, 32'h0, 32'h5, 32'h6, 4'd2, 1, 1, 0);
        sample();
        next_cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        ack(1, 32'hCAFEF00D);
        sample();
        chk("hold_req", 32'(bus.mem_req), 1);
        next_cycle();
        ack(0, 0);
        drive(32'h99, 32'h0, 32'h0, 32'h0, 4'd1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            sample();
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_result", bus.out_result, 32'hCAFEF00D);
            chk("hold_rd", 32'(bus.out_rd), 2);
            chk("hold_in_ready", 32'(bus.in_ready), 0);
            chk("hold_stall", 32'(bus.stall), 1);
        end
        next_cycle();
        bus.out_ready = 1'b1;
        sample();
        chk("hold_release_valid", 32'(bus.out_valid), 1);
        next_cycle();
        sample();
        chk("hold_after_valid", 32'(bus.out_valid), 0);
        chk("hold_after_ready", 32'(bus.in_ready), 1);
        next_cycle();
        bus.in_valid = 1'b0;
        sample();
        chk("hold_next_result", bus.out_result, 32'h99);
        next_cycle();
        sample();

        // Reset in the second request cycle; the late ack must be ignored
        next_cycle();
        drive(32'h30, 32'h0, 32'h0, 32'h0, 4'd4, 1, 1, 0);
        sample();
        next_cycle();
        bus.in_valid = 1'b0;
        sample();
        chk("rstacc_req1", 32'(bus.mem_req), 1);
        next_cycle();
        rst = 1'b0;
        sample();
        chk("rstacc_req2", 32'(bus.mem_req), 1);
        next_cycle();
        rst = 1'b1;
        ack(1, 32'h5555);
        sample();
        chk("rstacc_req_drop", 32'(bus.mem_req), 0);
        chk("rstacc_ready", 32'(bus.in_ready), 1);
        next_cycle();
        ack(0, 0);
        sample();
        chk("rstacc_no_valid", 32'(bus.out_valid), 0);
        chk("rstacc_no_req", 32'(bus.mem_req), 0);
        chk("rstacc_fwd", bus.fwd_mem, 0);

        // Simultaneous read and write behaves as a store
        next_cycle();
        drive(32'h50, 32'hABCD, 32'h0, 32'h0, 4'd9, 1, 1, 1);
        sample();
        next_cycle();
        bus.in_valid = 1'b0;
        ack(1, 32'h1111);
        sample();
        chk("rw_we", 32'(bus.mem_we), 1);
        chk("rw_wdata", bus.mem_wdata, 32'hABCD);
        next_cycle();
        ack(0, 0);
        sample();
        chk("rw_out_valid", 32'(bus.out_valid), 1);
        chk("rw_out_result", bus.out_result, 32'h50);
        chk("rw_no_rw", 32'(bus.out_reg_write), 0);
        next_cycle();
        sample();

        // Randomized traffic: build the expected transaction streams up front
        for (int k = 0; k < int'(K); k++) begin
            int kind;
            kind  = int'($urandom % 4);
            t.alu = $urandom;
            t.wd  = $urandom;
            t.ax  = $urandom;
            t.ay  = $urandom;
            t.rd  = 4'($urandom);
            t.rw  = 1'($urandom);
            t.mr  = (kind == 1) || (kind == 3);
            t.mw  = (kind >= 2);
            txns.push_back(t);
            m.addr  = t.alu;
            m.we    = t.mw;
            m.wdata = t.wd;
            m.rdata = $urandom;
            if (t.mr || t.mw) mreq_q.push_back(m);
            e.result = (t.mr && !t.mw) ? m.rdata : t.alu;
            e.ax     = t.ax;
            e.ay     = t.ay;
            e.rd     = t.rd;
            e.rw     = t.mw ? 1'b0 : t.rw;
            exp_q.push_back(e);
        end

        ti = 0; acc = 0; nout = 0; cyc = 0; wait_cnt = 0; req_seen = 0;
        while (nout < int'(K) && cyc < 4000) begin
            next_cycle();
            cyc++;
            bus.out_ready = ($urandom % 4) != 0;
            if (ti < int'(K) && ($urandom % 4) != 0)
                drive(txns[ti].alu, txns[ti].wd, txns[ti].ax, txns[ti].ay,
                      txns[ti].rd, txns[ti].rw, txns[ti].mr, txns[ti].mw);
            else
                bus.in_valid = 1'b0;
            if (bus.mem_req) begin
                if (!req_seen) begin
                    req_seen = 1;
                    wait_cnt = int'($urandom % 4);
                end
                if (wait_cnt == 0)
                    ack(1, (mreq_q.size() > 0) ? mreq_q[0].rdata : 32'h0);
                else begin
                    wait_cnt--;
                    ack(0, $urandom);
                end
            end else begin
                req_seen = 0;
                ack(($urandom % 8) == 0, $urandom);
            end
            sample();
            chk("rand_stall", 32'(bus.stall), 32'(bus.in_valid && !bus.in_ready));
            if (acc == nout) chk("rand_ready_empty", 32'(bus.in_ready), 1);
            if (bus.mem_req) begin
                if (mreq_q.size() == 0) chk("rand_unexpected_req", 1, 0);
                else begin
                    chk("rand_req_addr", bus.mem_addr, mreq_q[0].addr);
                    chk("rand_req_we", 32'(bus.mem_we), 32'(mreq_q[0].we));
                    if (mreq_q[0].we) chk("rand_req_wdata", bus.mem_wdata, mreq_q[0].wdata);
                    if (bus.mem_ack) void'(mreq_q.pop_front());
                end
            end
            if (bus.out_valid) chk("rand_fwd", bus.fwd_mem, bus.out_result);
            else chk("rand_rw_qual", 32'(bus.out_reg_write), 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("rand_unexpected_out", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rand_result", bus.out_result, e.result);
                    chk("rand_ax", bus.out_ax, e.ax);
                    chk("rand_ay", bus.out_ay, e.ay);
                    chk("rand_rd", 32'(bus.out_rd), 32'(e.rd));
                    chk("rand_rw", 32'(bus.out_reg_write), 32'(e.rw));
                end
                nout++;
            end
            if (bus.in_valid && bus.in_ready) begin
                ti++;
                acc++;
            end
        end
        chk("rand_all_delivered", 32'(nout), K);
        chk("rand_mem_drained", 32'(mreq_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
